// File: rtl/pe_accum_buffer.sv
// pe_accum_buffer: FIFO-fed, lane-serial accumulator for a 2-D output map, drained in raster order.
// Ports: clk/rst (async active-high); in_valid/in_last/data_in/data_in_cols/data_in_rows carry a 16-lane beat;
// out_valid/out_data/out_row/out_col/out_last stream finished cells; busy flags work pending; overflow is sticky.
module pe_accum_buffer #(
  parameter int col_length = 8,
  parameter int word_length = 8,
  parameter int acc_width = 20,
  parameter int image_size = 7,
  parameter int fifo_depth = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [16*word_length-1:0] data_in,
  input  logic [16*col_length-1:0]  data_in_cols,
  input  logic [16*col_length-1:0]  data_in_rows,
  output logic                      out_valid,
  output logic [acc_width-1:0]      out_data,
  output logic [col_length-1:0]     out_row,
  output logic [col_length-1:0]     out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overflow
);
  localparam int cells = image_size * image_size;
  localparam int aw = cells > 1 ? $clog2(cells) : 1;
  localparam int pw = fifo_depth > 1 ? $clog2(fifo_depth) : 1;
  localparam logic [aw-1:0] last_idx = aw'(cells - 1);
  localparam logic [col_length-1:0] img = col_length'(image_size);
  localparam logic [col_length-1:0] last_rc = col_length'(image_size - 1);
  localparam logic [pw-1:0] last_ptr = pw'(fifo_depth - 1);
  localparam logic [pw:0] depth = (pw + 1)'(fifo_depth);
  typedef enum logic [1:0] {IDLE, ACCUM, READ} state_t;
  state_t state;
  logic [16*word_length-1:0] f_data [fifo_depth];
  logic [16*col_length-1:0] f_cols [fifo_depth];
  logic [16*col_length-1:0] f_rows [fifo_depth];
  logic f_last [fifo_depth];
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [pw:0] count;
  logic [3:0] lane;
  logic [acc_width-1:0] acc [cells];
  logic [aw-1:0] rd_idx, a_idx;
  logic [col_length-1:0] rd_row, rd_col, l_row, l_col;
  logic [word_length-1:0] v;
  logic push, pop, more, hit;
  // A full FIFO rejects the beat even if the head pops this same cycle.
  assign push = in_valid && count != depth;
  assign pop = state == ACCUM && lane == 4'd15;
  // FIFO will still hold a beat next cycle; lets ACCUM/READ chain straight into ACCUM.
  assign more = push || count > {{pw{1'b0}}, pop};
  assign busy = state != IDLE || count != '0;
  assign v = f_data[rd_ptr][lane*word_length +: word_length];
  assign l_row = f_rows[rd_ptr][lane*col_length +: col_length];
  assign l_col = f_cols[rd_ptr][lane*col_length +: col_length];
  assign hit = l_row < img && l_col < img && v != '0;
  assign a_idx = aw'(int'(l_row) * image_size + int'(l_col));
  always_ff @(posedge clk)
    if (push) begin
      f_data[wr_ptr] <= data_in;
      f_cols[wr_ptr] <= data_in_cols;
      f_rows[wr_ptr] <= data_in_rows;
      f_last[wr_ptr] <= in_last;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lane <= '0;
      rd_idx <= '0;
      rd_row <= '0;
      rd_col <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < cells; i++) acc[i] <= '0;
    end else begin
      overflow <= overflow || (in_valid && !push);
      if (push) wr_ptr <= wr_ptr == last_ptr ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == last_ptr ? '0 : rd_ptr + 1'b1;
      count <= count + {{pw{1'b0}}, push} - {{pw{1'b0}}, pop};
      lane <= state == ACCUM ? lane + 1'b1 : '0;
      out_valid <= state == READ;
      out_last <= state == READ && rd_idx == last_idx;
      if (state == ACCUM && hit) acc[a_idx] <= acc[a_idx] + {{(acc_width-word_length){v[word_length-1]}}, v};
      if (state == READ) begin
        out_data <= acc[rd_idx];
        out_row <= rd_row;
        out_col <= rd_col;
        acc[rd_idx] <= '0;
        rd_idx <= rd_idx == last_idx ? '0 : rd_idx + 1'b1;
        rd_col <= rd_col == last_rc ? '0 : rd_col + 1'b1;
        if (rd_col == last_rc) rd_row <= rd_row == last_rc ? '0 : rd_row + 1'b1;
      end
      state <= state == IDLE ? (count != '0 ? ACCUM : IDLE) :
               state == ACCUM ? (!pop ? ACCUM : f_last[rd_ptr] ? READ : more ? ACCUM : IDLE) :
               (rd_idx != last_idx ? READ : more ? ACCUM : IDLE);
    end
endmodule
